// File: rtl/riscv_check_pkg.sv
// Shared types for the RISC-V commit checker: entry kinds, checker states and
// the expectation-table entry payload.
package riscv_check_pkg;

  localparam int unsigned CHK_XLEN = 32;
  localparam int unsigned KIND_W   = 3;

  typedef enum logic [KIND_W-1:0] {
    KIND_NONE   = 3'd0,
    KIND_RESULT = 3'd1,
    KIND_STORE  = 3'd2,
    KIND_LOAD   = 3'd3,
    KIND_LOOP   = 3'd4,
    KIND_END    = 3'd5
  } chk_kind_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2,
    ST_ERR  = 2'd3
  } chk_state_e;

  typedef struct packed {
    logic [CHK_XLEN-1:0] pc;
    chk_kind_e           kind;
    logic [CHK_XLEN-1:0] exp;
    logic [CHK_XLEN-1:0] exp_addr;
  } chk_entry_t;

  // Unused encodings collapse to NONE so a stray kind can never match a PC.
  function automatic chk_kind_e to_kind(input logic [KIND_W-1:0] raw);
    if (raw > KIND_W'(5)) begin
      return KIND_NONE;
    end
    return chk_kind_e'(raw);
  endfunction

endpackage

// File: rtl/riscv_check_table.sv
// Expectation table: entry storage plus a lowest-index-wins PC match.
module riscv_check_table
  import riscv_check_pkg::*;
#(
  parameter int unsigned NUM_CHECKS = 64
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          wr_en_i,
  input  logic [$clog2(NUM_CHECKS)-1:0] wr_idx_i,
  input  chk_entry_t                    wr_entry_i,
  input  logic [CHK_XLEN-1:0]           pc_i,
  output logic                          hit_c_o,
  output logic [$clog2(NUM_CHECKS)-1:0] idx_c_o,
  output chk_entry_t                    entry_c_o
);

  localparam int unsigned IDX_W = $clog2(NUM_CHECKS);

  chk_entry_t tbl_q [NUM_CHECKS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_CHECKS; i++) begin
        tbl_q[i] <= '0;
      end
    end else if (wr_en_i) begin
      tbl_q[wr_idx_i] <= wr_entry_i;
    end
  end

  // Scan from the top down so the lowest matching index is the one left standing.
  always_comb begin
    hit_c_o = 1'b0;
    idx_c_o = '0;
    for (int i = int'(NUM_CHECKS) - 1; i >= 0; i--) begin
      if ((tbl_q[i].kind != KIND_NONE) && (tbl_q[i].pc == pc_i)) begin
        hit_c_o = 1'b1;
        idx_c_o = IDX_W'(i);
      end
    end
  end

  assign entry_c_o = tbl_q[idx_c_o];

endmodule

// File: rtl/riscv_commit_checker.sv
// Table-driven retirement checker: samples the core's writeback/store bus,
// scores it against programmed expectations and flags loops and hangs.
module riscv_commit_checker
  import riscv_check_pkg::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned NUM_CHECKS = 64,
  parameter int unsigned LOOP_LIMIT = 16,
  parameter int unsigned TIMEOUT    = 4096
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          cfg_we,
  input  logic [$clog2(NUM_CHECKS)-1:0] cfg_idx,
  input  logic [XLEN-1:0]               cfg_pc,
  input  logic [2:0]                    cfg_kind,
  input  logic [XLEN-1:0]               cfg_exp,
  input  logic [XLEN-1:0]               cfg_exp_addr,
  input  logic                          start,
  input  logic [XLEN-1:0]               PC,
  input  logic [XLEN-1:0]               Result,
  input  logic                          MemWrite,
  input  logic [XLEN-1:0]               DataAdr,
  input  logic [XLEN-1:0]               WriteData,
  output logic                          busy,
  output logic                          done,
  output logic                          stuck,
  output logic [$clog2(NUM_CHECKS):0]   pass_count,
  output logic [$clog2(NUM_CHECKS):0]   fail_count,
  output logic [$clog2(NUM_CHECKS)-1:0] first_fail_idx,
  output logic [XLEN-1:0]               first_fail_got
);

  localparam int unsigned IDX_W = $clog2(NUM_CHECKS);
  localparam int unsigned CNT_W = IDX_W + 1;
  localparam int unsigned LC_W  = $clog2(LOOP_LIMIT + 2);
  localparam int unsigned TM_W  = $clog2(TIMEOUT + 1);

  // Stage 1: bus sample.
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] result_q;
  logic            memwrite_q;
  logic [XLEN-1:0] dataadr_q;
  logic [XLEN-1:0] wdata_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q       <= '0;
      result_q   <= '0;
      memwrite_q <= 1'b0;
      dataadr_q  <= '0;
      wdata_q    <= '0;
    end else begin
      pc_q       <= PC;
      result_q   <= Result;
      memwrite_q <= MemWrite;
      dataadr_q  <= DataAdr;
      wdata_q    <= WriteData;
    end
  end

  chk_state_e            state_q;
  logic                  busy_q;
  logic                  done_q;
  logic                  stuck_q;
  logic [CNT_W-1:0]      pass_cnt_q;
  logic [CNT_W-1:0]      fail_cnt_q;
  logic [IDX_W-1:0]      ff_idx_q;
  logic [XLEN-1:0]       ff_got_q;
  logic [NUM_CHECKS-1:0] visited_q;
  logic [LC_W-1:0]       loop_cnt_q [NUM_CHECKS];
  logic [TM_W-1:0]       timer_q;

  logic       tbl_we_c;
  chk_entry_t wr_entry_c;

  // A start in the same cycle as a table write wins; the write is dropped.
  always_comb begin
    tbl_we_c            = cfg_we && (state_q == ST_IDLE) && !start;
    wr_entry_c.pc       = CHK_XLEN'(cfg_pc);
    wr_entry_c.kind     = to_kind(cfg_kind);
    wr_entry_c.exp      = CHK_XLEN'(cfg_exp);
    wr_entry_c.exp_addr = CHK_XLEN'(cfg_exp_addr);
  end

  logic             tbl_hit_c;
  logic [IDX_W-1:0] tbl_idx_c;
  chk_entry_t       tbl_entry_c;

  riscv_check_table #(
    .NUM_CHECKS (NUM_CHECKS)
  ) u_table (
    .clk        (clk),
    .rst_n      (reset),
    .wr_en_i    (tbl_we_c),
    .wr_idx_i   (cfg_idx),
    .wr_entry_i (wr_entry_c),
    .pc_i       (CHK_XLEN'(pc_q)),
    .hit_c_o    (tbl_hit_c),
    .idx_c_o    (tbl_idx_c),
    .entry_c_o  (tbl_entry_c)
  );

  logic            run_c;
  logic            hit_c;
  logic            ok_c;
  logic            score_c;
  logic            loop_c;
  logic            loop_err_c;
  logic            end_c;
  logic            timeout_c;
  logic [XLEN-1:0] exp_c;
  logic [XLEN-1:0] exp_addr_c;
  logic [XLEN-1:0] got_c;
  logic [LC_W-1:0] loop_nxt_c;
  logic [TM_W-1:0] timer_nxt_c;

  // Stage 2: verdict on the sampled bus. Comparisons sit in if-conditions so an
  // unknown bus value falls through to a fail.
  always_comb begin
    run_c      = (state_q == ST_RUN);
    exp_c      = XLEN'(tbl_entry_c.exp);
    exp_addr_c = XLEN'(tbl_entry_c.exp_addr);
    hit_c      = tbl_hit_c && (tbl_entry_c.pc == CHK_XLEN'(pc_q));
    ok_c       = 1'b0;
    case (tbl_entry_c.kind)
      KIND_RESULT, KIND_END: begin
        if (result_q == exp_c) ok_c = 1'b1;
      end
      KIND_STORE: begin
        if (memwrite_q && (dataadr_q == exp_addr_c) && (wdata_q == exp_c)) ok_c = 1'b1;
      end
      KIND_LOAD: begin
        if ((dataadr_q == exp_addr_c) && (result_q == exp_c)) ok_c = 1'b1;
      end
      default: ok_c = 1'b0;
    endcase

    got_c   = (tbl_entry_c.kind == KIND_STORE) ? wdata_q : result_q;
    score_c = run_c && hit_c && (tbl_entry_c.kind != KIND_LOOP) && !visited_q[tbl_idx_c];
    loop_c  = run_c && hit_c && (tbl_entry_c.kind == KIND_LOOP);
    end_c   = score_c && (tbl_entry_c.kind == KIND_END);

    if (loop_cnt_q[tbl_idx_c] == LC_W'(LOOP_LIMIT + 1)) begin
      loop_nxt_c = loop_cnt_q[tbl_idx_c];
    end else begin
      loop_nxt_c = loop_cnt_q[tbl_idx_c] + LC_W'(1);
    end
    loop_err_c = loop_c && ((loop_nxt_c > LC_W'(LOOP_LIMIT)) || (result_q > exp_c));

    if (hit_c) begin
      timer_nxt_c = '0;
    end else if (timer_q == TM_W'(TIMEOUT)) begin
      timer_nxt_c = timer_q;
    end else begin
      timer_nxt_c = timer_q + TM_W'(1);
    end
    timeout_c = run_c && !hit_c && (timer_nxt_c >= TM_W'(TIMEOUT));
  end

  // Checker FSM with its scoreboard; DONE and ERR are left only through reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      stuck_q    <= 1'b0;
      pass_cnt_q <= '0;
      fail_cnt_q <= '0;
      ff_idx_q   <= '0;
      ff_got_q   <= '0;
      visited_q  <= '0;
      timer_q    <= '0;
      for (int unsigned i = 0; i < NUM_CHECKS; i++) begin
        loop_cnt_q[i] <= '0;
      end
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q <= ST_RUN;
            busy_q  <= 1'b1;
          end
        end
        ST_RUN: begin
          timer_q <= timer_nxt_c;
          if (score_c) begin
            visited_q[tbl_idx_c] <= 1'b1;
            if (ok_c) begin
              if (pass_cnt_q != '1) pass_cnt_q <= pass_cnt_q + CNT_W'(1);
            end else begin
              if (fail_cnt_q == '0) begin
                ff_idx_q <= tbl_idx_c;
                ff_got_q <= got_c;
              end
              if (fail_cnt_q != '1) fail_cnt_q <= fail_cnt_q + CNT_W'(1);
            end
          end
          if (loop_c) begin
            loop_cnt_q[tbl_idx_c] <= loop_nxt_c;
          end
          if (end_c) begin
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= ST_DONE;
          end else if (loop_err_c || timeout_c) begin
            stuck_q <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= ST_ERR;
          end
        end
        default: begin
          state_q <= state_q;
        end
      endcase
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign stuck          = stuck_q;
  assign pass_count     = pass_cnt_q;
  assign fail_count     = fail_cnt_q;
  assign first_fail_idx = ff_idx_q;
  assign first_fail_got = ff_got_q;

endmodule

// File: tb/tb_riscv_commit_checker.sv
// Randomized and directed bench for riscv_commit_checker against a behavioural
// scoreboard of the expectation table.
module tb_riscv_commit_checker;

  localparam int unsigned XLEN = 32;
  localparam int unsigned NCHK = 16;
  localparam int unsigned LLIM = 16;
  localparam int unsigned TMO  = 32;
  localparam int unsigned IW   = $clog2(NCHK);
  localparam int unsigned CW   = IW + 1;

  localparam int K_NONE = 0, K_RESULT = 1, K_STORE = 2, K_LOAD = 3, K_LOOP = 4, K_END = 5;
  localparam int S_IDLE = 0, S_RUN = 1, S_DONE = 2, S_ERR = 3;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            cfg_we = 1'b0;
  logic [IW-1:0]   cfg_idx = '0;
  logic [XLEN-1:0] cfg_pc = '0;
  logic [2:0]      cfg_kind = '0;
  logic [XLEN-1:0] cfg_exp = '0;
  logic [XLEN-1:0] cfg_exp_addr = '0;
  logic            start = 1'b0;
  logic [XLEN-1:0] PC = 32'h1000;
  logic [XLEN-1:0] Result = '0;
  logic            MemWrite = 1'b0;
  logic [XLEN-1:0] DataAdr = '0;
  logic [XLEN-1:0] WriteData = '0;
  logic            busy, done, stuck;
  logic [CW-1:0]   pass_count, fail_count;
  logic [IW-1:0]   first_fail_idx;
  logic [XLEN-1:0] first_fail_got;

  riscv_commit_checker #(
    .XLEN(XLEN), .NUM_CHECKS(NCHK), .LOOP_LIMIT(LLIM), .TIMEOUT(TMO)
  ) dut (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_pc(cfg_pc),
    .cfg_kind(cfg_kind), .cfg_exp(cfg_exp), .cfg_exp_addr(cfg_exp_addr), .start(start),
    .PC(PC), .Result(Result), .MemWrite(MemWrite), .DataAdr(DataAdr), .WriteData(WriteData),
    .busy(busy), .done(done), .stuck(stuck), .pass_count(pass_count), .fail_count(fail_count),
    .first_fail_idx(first_fail_idx), .first_fail_got(first_fail_got)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- behavioural reference ----------------
  typedef struct {
    logic [31:0] pc;
    int          kind;
    logic [31:0] exp;
    logic [31:0] addr;
  } ment_t;

  ment_t       mt [NCHK];
  bit          mvis [NCHK];
  int          mvisits [NCHK];
  int          m_st, m_pass, m_fail, m_ffidx, m_idle_cycles;
  logic [31:0] m_ffgot;
  bit          m_done, m_stuck;
  logic [31:0] p_pc, p_res, p_adr, p_wd;
  bit          p_mw;

  function automatic void mdl_reset();
    for (int i = 0; i < int'(NCHK); i++) begin
      mt[i] = '{32'h0, K_NONE, 32'h0, 32'h0};
      mvis[i] = 1'b0;
      mvisits[i] = 0;
    end
    m_st = S_IDLE; m_pass = 0; m_fail = 0; m_ffidx = 0; m_ffgot = '0;
    m_done = 1'b0; m_stuck = 1'b0; m_idle_cycles = 0;
    p_pc = '0; p_res = '0; p_adr = '0; p_wd = '0; p_mw = 1'b0;
  endfunction

  function automatic void mdl_eval();
    int  hit_i;
    bit  ok;
    hit_i = -1;
    for (int i = 0; i < int'(NCHK); i++) begin
      if (hit_i < 0 && mt[i].kind != K_NONE && mt[i].pc == p_pc) hit_i = i;
    end
    if (hit_i < 0) begin
      m_idle_cycles++;
      if (m_idle_cycles >= int'(TMO)) begin m_stuck = 1'b1; m_st = S_ERR; end
      return;
    end
    m_idle_cycles = 0;
    if (mt[hit_i].kind == K_LOOP) begin
      mvisits[hit_i]++;
      if (mvisits[hit_i] > int'(LLIM) || p_res > mt[hit_i].exp) begin
        m_stuck = 1'b1; m_st = S_ERR;
      end
      return;
    end
    if (mvis[hit_i]) return;
    mvis[hit_i] = 1'b1;
    case (mt[hit_i].kind)
      K_STORE: ok = p_mw && p_adr == mt[hit_i].addr && p_wd == mt[hit_i].exp;
      K_LOAD:  ok = p_adr == mt[hit_i].addr && p_res == mt[hit_i].exp;
      default: ok = p_res == mt[hit_i].exp;
    endcase
    if (ok) begin
      if (m_pass < (1 << CW) - 1) m_pass++;
    end else begin
      if (m_fail == 0) begin
        m_ffidx = hit_i;
        m_ffgot = (mt[hit_i].kind == K_STORE) ? p_wd : p_res;
      end
      if (m_fail < (1 << CW) - 1) m_fail++;
    end
    if (mt[hit_i].kind == K_END) begin m_done = 1'b1; m_st = S_DONE; end
  endfunction

  function automatic void mdl_edge();
    if (m_st == S_IDLE) begin
      if (start) m_st = S_RUN;
      else if (cfg_we) mt[cfg_idx] = '{cfg_pc, (int'(cfg_kind) > 5) ? K_NONE : int'(cfg_kind), cfg_exp, cfg_exp_addr};
    end else if (m_st == S_RUN) begin
      mdl_eval();
    end
    p_pc = PC; p_res = Result; p_mw = MemWrite; p_adr = DataAdr; p_wd = WriteData;
  endfunction

  task automatic compare_all();
    check_eq("busy", busy, (m_st == S_RUN));
    check_eq("done", done, m_done);
    check_eq("stuck", stuck, m_stuck);
    check_eq("pass_count", pass_count, m_pass);
    check_eq("fail_count", fail_count, m_fail);
    check_eq("first_fail_idx", first_fail_idx, m_ffidx);
    check_eq("first_fail_got", first_fail_got, m_ffgot);
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    mdl_edge();
    #1;
    compare_all();
  endtask

  task automatic bus_idle();
    PC = 32'h1000; Result = '0; MemWrite = 1'b0; DataAdr = '0; WriteData = '0;
  endtask

  task automatic do_reset();
    reset = 1'b0; cfg_we = 1'b0; start = 1'b0;
    bus_idle();
    #1;
    mdl_reset();
    compare_all();
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic cfg_write(input int idx, input logic [31:0] pc, input int kind,
                           input logic [31:0] exp, input logic [31:0] addr);
    cfg_we = 1'b1; cfg_idx = IW'(idx); cfg_pc = pc; cfg_kind = 3'(kind);
    cfg_exp = exp; cfg_exp_addr = addr;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic start_run();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic bus(input logic [31:0] pc, input logic [31:0] res, input logic mw,
                     input logic [31:0] adr, input logic [31:0] wd);
    PC = pc; Result = res; MemWrite = mw; DataAdr = adr; WriteData = wd;
    tick();
  endtask

  initial begin
    int n;
    do_reset();
    check_eq("reset_busy", busy, 0);
    check_eq("reset_pass", pass_count, 0);

    // 1: two RESULT checks then END
    cfg_write(0, 32'h10, K_RESULT, 9, 0);
    cfg_write(1, 32'h14, K_RESULT, 64, 0);
    cfg_write(2, 32'h18, K_END, 0, 0);
    start_run();
    bus(32'h10, 9, 0, 0, 0);
    bus(32'h14, 64, 0, 0, 0);
    bus(32'h18, 0, 0, 0, 0);
    bus(32'h1000, 0, 0, 0, 0);
    check_eq("t1_pass", pass_count, 3);
    check_eq("t1_fail", fail_count, 0);
    check_eq("t1_done", done, 1);
    check_eq("t1_busy", busy, 0);

    // 2: failing STORE, passing LOAD
    do_reset();
    cfg_write(5, 32'h6C, K_STORE, 16, 40);
    cfg_write(6, 32'h70, K_LOAD, 7, 44);
    start_run();
    bus(32'h6C, 0, 1, 40, 15);
    bus(32'h70, 7, 0, 44, 0);
    bus(32'h1000, 0, 0, 0, 0);
    check_eq("t2_fail", fail_count, 1);
    check_eq("t2_pass", pass_count, 1);
    check_eq("t2_ffidx", first_fail_idx, 5);
    check_eq("t2_ffgot", first_fail_got, 15);

    // 3a: LOOP exceeds visit limit on visit 17
    do_reset();
    cfg_write(3, 32'h90, K_LOOP, 10, 0);
    start_run();
    for (int i = 0; i < 17; i++) bus(32'h90, 32'($urandom_range(0, 10)), 0, 0, 0);
    check_eq("t3a_stuck_pre", stuck, 0);
    bus(32'h1000, 0, 0, 0, 0);
    check_eq("t3a_stuck", stuck, 1);
    check_eq("t3a_busy", busy, 0);

    // 3b: LOOP bound violated on visit 3
    do_reset();
    cfg_write(3, 32'h90, K_LOOP, 10, 0);
    start_run();
    bus(32'h90, 5, 0, 0, 0);
    bus(32'h90, 10, 0, 0, 0);
    bus(32'h90, 11, 0, 0, 0);
    check_eq("t3b_stuck_pre", stuck, 0);
    bus(32'h1000, 0, 0, 0, 0);
    check_eq("t3b_stuck", stuck, 1);

    // 4: timeout measured from last hit
    do_reset();
    cfg_write(0, 32'h10, K_RESULT, 9, 0);
    start_run();
    bus(32'h10, 9, 0, 0, 0);
    bus(32'h200, 0, 0, 0, 0);
    check_eq("t4_pass", pass_count, 1);
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      bus(32'h200, 0, 0, 0, 0);
      if (stuck && n == 0) n = i;
    end
    check_eq("t4_timeout_cycles", n, TMO);

    // 5: re-hits are not rescored
    do_reset();
    cfg_write(2, 32'h10, K_RESULT, 9, 0);
    start_run();
    for (int i = 0; i < 5; i++) bus(32'h10, (i == 0) ? 32'd9 : 32'd8, 0, 0, 0);
    bus(32'h1000, 0, 0, 0, 0);
    check_eq("t5_pass", pass_count, 1);
    check_eq("t5_fail", fail_count, 0);

    // 6: async reset mid-RUN, then an empty table never completes
    do_reset();
    for (int i = 0; i < 4; i++) cfg_write(i, 32'h10 + 32'(4 * i), K_RESULT, 32'(i), 0);
    start_run();
    for (int i = 0; i < 4; i++) bus(32'h10 + 32'(4 * i), 32'(i), 0, 0, 0);
    bus(32'h1000, 0, 0, 0, 0);
    check_eq("t6_pass_pre", pass_count, 4);
    #2 reset = 1'b0;
    #1;
    check_eq("t6_async_pass", pass_count, 0);
    check_eq("t6_async_busy", busy, 0);
    mdl_reset();
    compare_all();
    @(negedge clk);
    reset = 1'b1;
    start_run();
    for (int i = 0; i < 20; i++) bus(32'h10 + 32'(4 * $urandom_range(0, 3)), 32'($urandom_range(0, 3)), 0, 0, 0);
    check_eq("t6_no_done", done, 0);

    // 7: random tables and traffic against the scoreboard
    for (int r = 0; r < 20; r++) begin
      do_reset();
      for (int e = 0; e < 8; e++)
        cfg_write(int'($urandom_range(0, NCHK - 1)), 32'h100 + 32'(4 * $urandom_range(0, 7)),
                  int'($urandom_range(0, 5)), 32'($urandom_range(0, 3)), 32'($urandom_range(0, 3)));
      cfg_we = 1'($urandom_range(0, 1)); cfg_idx = IW'($urandom_range(0, NCHK - 1));
      cfg_pc = 32'h100; cfg_kind = 3'(K_END); cfg_exp = 0;
      start_run();
      for (int c = 0; c < 60; c++) begin
        cfg_we = 1'($urandom_range(0, 1));
        bus(($urandom_range(0, 3) == 0) ? 32'h300 : 32'h100 + 32'(4 * $urandom_range(0, 7)),
            32'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            32'($urandom_range(0, 3)), 32'($urandom_range(0, 3)));
      end
      cfg_we = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/riscv_commit_checker.md
Name: riscv_commit_checker

Overview:
- Synthesizable, table-driven retirement checker for the single-cycle RISC-V core.
- Samples PC, Result and store-bus signals every cycle and matches PC against a programmable table of expected outcomes.
- Counts passes and fails, captures the first failure, and detects runaway loops and hangs.
- Sits beside riscv_cpu_main in simulation and in FPGA bring-up builds; results are read back over debug outputs.

Parameters:
XLEN, 32, datapath and PC width
NUM_CHECKS, 64, number of expectation-table entries (power of 2, ≥2)
LOOP_LIMIT, 16, maximum visits allowed to a LOOP entry before a stuck error
TIMEOUT, 4096, maximum cycles without any table hit before a hang error

Ports:
clk  in  1  core clock
reset  in  1  asynchronous, active-low reset (0 = reset)
cfg_we  in  1  table write strobe; accepted only in IDLE
cfg_idx  in  $clog2(NUM_CHECKS)  entry index
cfg_pc  in  XLEN  PC the entry matches
cfg_kind  in  3  NONE/RESULT/STORE/LOAD/LOOP/END
cfg_exp  in  XLEN  expected Result or store data; loop upper bound for LOOP
cfg_exp_addr  in  XLEN  expected DataAdr for STORE/LOAD
start  in  1  arm checker (IDLE->RUN)
PC  in  XLEN  core PC
Result  in  XLEN  core writeback value
MemWrite  in  1  core store strobe
DataAdr  in  XLEN  core data address
WriteData  in  XLEN  core store data
busy  out  1  state == RUN
done  out  1  END entry retired, sticky until reset
stuck  out  1  loop-limit or timeout error, sticky until reset
pass_count  out  $clog2(NUM_CHECKS)+1  checks passed
fail_count  out  $clog2(NUM_CHECKS)+1  checks failed
first_fail_idx  out  $clog2(NUM_CHECKS)  index of first failing entry
first_fail_got  out  XLEN  observed value at first failure

Behaviour:
- Reset: all outputs 0; state IDLE; table kinds = NONE; visited bits and loop counters cleared.
- States:
  - IDLE: cfg writes accepted; start -> RUN (start wins over a same-cycle cfg_we, and that write is dropped).
  - RUN: check PC every cycle. END hit -> DONE. Error -> ERR.
  - DONE and ERR: terminal; exit only by reset.
- Latency:
  - Stage 1: register PC, Result, MemWrite, DataAdr and WriteData at posedge.
  - Stage 2: compare; counters update on the next posedge (2-cycle latency from bus to count).
- Match: lowest-index entry with kind != NONE and cfg_pc == PC. Duplicate PCs resolve to the lowest index.
- Pass criteria per kind:
  - RESULT: Result == exp.
  - STORE: MemWrite=1, DataAdr == exp_addr, and WriteData == exp. MemWrite=0 counts as fail.
  - LOAD: DataAdr == exp_addr and Result == exp.
  - LOOP: no pass/fail. Visit counter increments; if visits > LOOP_LIMIT or unsigned Result > exp, set stuck -> ERR.
  - END: evaluated as RESULT, then done=1.
- Non-LOOP entries are scored once. A visited bit is set on first hit; later hits are ignored.
- Fail capture: first_fail_idx and first_fail_got latch only on the first fail. got = WriteData for STORE, Result otherwise.
- Timeout: counter resets on any table hit. When it reaches TIMEOUT in RUN: stuck=1 -> ERR. Counter saturates and does not wrap.
- Counters saturate at all-ones.
- Comparisons are bitwise equality; X/Z on the bus counts as fail.
- Reset mid-RUN: immediate return to IDLE with the table cleared.

Decomposition:
- Package riscv_check_pkg holds:
  - kind encodings (NONE=0, RESULT=1, STORE=2, LOAD=3, LOOP=4, END=5);
  - state encodings;
  - the check-entry struct {pc, kind, exp, exp_addr}.
- Sub-module riscv_check_table:
  - storage plus priority-encoded PC match;
  - outputs hit, idx, and the matched entry.

Test Plan:
1. Load entries 0x10 RESULT 9 and 0x14 RESULT 64, END at 0x18 exp 0; drive matching values -> pass_count=3, fail_count=0, done=1.
2. Entry 0x6C STORE addr 40 data 16; drive MemWrite=1, DataAdr=40, WriteData=15 -> fail_count=1, first_fail_idx=entry, first_fail_got=15.
3. LOOP at 0x90, exp 10, LOOP_LIMIT=16; revisit 0x90 17 times with Result≤10 -> stuck=1 and ERR on the 17th visit; with Result=11 on the 3rd visit -> stuck at that visit.
4. TIMEOUT=32; hold PC at an unmatched 0x200 after start -> stuck=1 exactly 32 cycles after the last hit.
5. Re-hit RESULT entry 0x10 five times -> scored once; pass_count increments by 1 only.
6. Assert reset low mid-RUN with pass_count=4 -> all outputs 0 asynchronously; state IDLE; a subsequent start with an empty table never asserts done.
